// File: rtl/sprite_row_loader_if.sv
`default_nettype none
// ============================================================================
// sprite_row_loader_if : sprite record type and loader bus bundle
// Rev 1.0 : initial release
// ============================================================================

package sprite_row_loader_pkg;
    typedef struct packed {
        logic [8:0]   x;
        logic [1:0]   w;
        logic         x_mirror;
        logic [2:0]   palette;
        logic         fg_prio;
        logic         bg_prio;
        logic [127:0] pattern;
    } sprite_reg_t;
endpackage

interface sprite_row_loader_if #(
    parameter int OAM_ENTRIES = 64
) ();
    localparam int AW = $clog2(OAM_ENTRIES);

    logic                               row_start;
    logic [7:0]                         row;
    logic [AW-1:0]                      oam_addr;
    logic [35:0]                        oam_data;
    logic [10:0]                        pat_addr;
    logic [31:0]                        pat_data;
    sprite_row_loader_pkg::sprite_reg_t out;
    logic                               out_valid;
    logic                               out_ack;
    logic                               busy;
    logic                               done;

    modport slave (
        input  row_start, row, oam_data, pat_data, out_ack,
        output oam_addr, pat_addr, out, out_valid, busy, done
    );

    modport master (
        output row_start, row, oam_data, pat_data, out_ack,
        input  oam_addr, pat_addr, out, out_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_row_loader.sv
`default_nettype none
// ============================================================================
// sprite_row_loader : scans OAM for one scanline, fetches tile rows, pushes records
// Rev 1.0 : initial release
// ============================================================================

module sprite_row_loader #(
    parameter int OAM_ENTRIES = 64,
    parameter int MAX_PER_ROW = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sprite_row_loader_if.slave bus
);
    localparam int AW = $clog2(OAM_ENTRIES);
    localparam int CW = $clog2(MAX_PER_ROW + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(OAM_ENTRIES - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PER_ROW);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONF_RD  = 3'd1,
        S_CONF_CHK = 3'd2,
        S_PAT_RD   = 3'd3,
        S_PAT_WR   = 3'd4,
        S_PUSH     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                             state_q;
    logic [7:0]                         row_q;
    logic [AW-1:0]                      index_q;
    logic [CW-1:0]                      count_q;
    logic [1:0]                         tx_q;
    logic [4:0]                         ry_q;
    logic [7:0]                         tile_q;
    logic [10:0]                        pat_addr_q;
    sprite_row_loader_pkg::sprite_reg_t out_q;
    logic                               out_valid_q;
    logic                               done_q;

    logic [7:0] ent_y;
    logic [1:0] ent_h;
    logic [7:0] ent_dy;
    logic [4:0] ent_last;
    logic [4:0] ent_ry;
    logic       ent_hit;

    // ent_last = 8*(h+1)-1, the last sprite line relative to y
    assign ent_y    = bus.oam_data[16:9];
    assign ent_h    = bus.oam_data[20:19];
    assign ent_dy   = row_q - ent_y;
    assign ent_last = {ent_h, 3'b111};
    assign ent_hit  = (row_q >= ent_y) && (ent_dy <= {3'b000, ent_last});
    assign ent_ry   = bus.oam_data[22] ? (ent_last - ent_dy[4:0]) : ent_dy[4:0];

    function automatic logic [10:0] pat_addr_of(input logic [7:0] tile,
                                                input logic [4:0] ry,
                                                input logic [1:0] tx);
        logic [7:0] t;
        t = tile + {4'b0000, ry[4:3], 2'b00} + {6'b000000, tx};
        return {t, ry[2:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            index_q     <= '0;
            count_q     <= '0;
            tx_q        <= '0;
            ry_q        <= '0;
            tile_q      <= '0;
            pat_addr_q  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.row_start && (state_q != S_IDLE)) begin
                // abandon the current scan without signalling done
                row_q       <= bus.row;
                index_q     <= '0;
                count_q     <= '0;
                tx_q        <= '0;
                out_valid_q <= 1'b0;
                state_q     <= S_CONF_RD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.row_start) begin
                            row_q   <= bus.row;
                            index_q <= '0;
                            count_q <= '0;
                            state_q <= S_CONF_RD;
                        end
                    end
                    S_CONF_RD: state_q <= S_CONF_CHK;
                    S_CONF_CHK: begin
                        if (ent_hit) begin
                            out_q.x        <= bus.oam_data[8:0];
                            out_q.w        <= bus.oam_data[18:17];
                            out_q.x_mirror <= bus.oam_data[21];
                            out_q.palette  <= bus.oam_data[25:23];
                            out_q.fg_prio  <= bus.oam_data[26];
                            out_q.bg_prio  <= bus.oam_data[27];
                            out_q.pattern  <= '0;
                            tile_q         <= bus.oam_data[35:28];
                            ry_q           <= ent_ry;
                            tx_q           <= 2'd0;
                            pat_addr_q     <= pat_addr_of(bus.oam_data[35:28], ent_ry, 2'd0);
                            state_q        <= S_PAT_RD;
                        end else if (index_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            index_q <= index_q + AW'(1);
                            state_q <= S_CONF_RD;
                        end
                    end
                    S_PAT_RD: state_q <= S_PAT_WR;
                    S_PAT_WR: begin
                        out_q.pattern[{tx_q, 5'b00000} +: 32] <= bus.pat_data;
                        if (tx_q == out_q.w) begin
                            out_valid_q <= 1'b1;
                            state_q     <= S_PUSH;
                        end else begin
                            tx_q       <= tx_q + 2'd1;
                            pat_addr_q <= pat_addr_of(tile_q, ry_q, tx_q + 2'd1);
                            state_q    <= S_PAT_RD;
                        end
                    end
                    S_PUSH: begin
                        if (bus.out_ack) begin
                            out_valid_q <= 1'b0;
                            count_q     <= count_q + CW'(1);
                            if (((count_q + CW'(1)) == MAX_CNT) || (index_q == LAST_IDX)) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                index_q <= index_q + AW'(1);
                                state_q <= S_CONF_RD;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.oam_addr  = index_q;
    assign bus.pat_addr  = pat_addr_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;

endmodule
`default_nettype wire
